// File: rtl/cmp_rr_sched.sv
// cmp_rr_sched: one 32-bit branch comparator shared by NREQ requesters.
// Round-robin arbitration with a combinational one-hot grant, and a
// single-entry registered response stage that carries the requester ID.
module cmp_rr_sched #(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [NREQ-1:0]      i_req_valid,
    output logic [NREQ-1:0]      o_req_ready,
    input  logic [32*NREQ-1:0]   i_req_a,
    input  logic [32*NREQ-1:0]   i_req_b,
    input  logic [3*NREQ-1:0]    i_req_cmpop,
    output logic                 o_rsp_valid,
    input  logic                 i_rsp_ready,
    output logic                 o_rsp_taken,
    output logic [IDW-1:0]       o_rsp_id,
    output logic                 o_rsp_illegal
);

    localparam logic [2:0] OP_BEQ  = 3'b000;
    localparam logic [2:0] OP_BNE  = 3'b001;
    localparam logic [2:0] OP_BLT  = 3'b100;
    localparam logic [2:0] OP_BGE  = 3'b101;
    localparam logic [2:0] OP_BLTU = 3'b110;
    localparam logic [2:0] OP_BGEU = 3'b111;

    typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

    state_t          r_state;
    logic [IDW-1:0]  r_ptr;
    logic            r_taken;
    logic [IDW-1:0]  r_id;
    logic            r_illegal;

    logic            w_can_accept;
    logic            w_found;
    logic            w_xfer;
    logic [IDW:0]    w_sum;
    logic [IDW-1:0]  w_gidx;
    logic [IDW-1:0]  w_ptr_nxt;
    logic [NREQ-1:0] w_grant;
    logic [31:0]     w_a;
    logic [31:0]     w_b;
    logic [2:0]      w_op;
    logic [1:0]      w_res;

    // Returns {taken, illegal}; illegal encodings never report taken.
    function automatic logic [1:0] cmp_eval(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] op);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        case (op)
            OP_BEQ:  return {a == b, 1'b0};
            OP_BNE:  return {a != b, 1'b0};
            OP_BLT:  return {sa < sb, 1'b0};
            OP_BGE:  return {sa >= sb, 1'b0};
            OP_BLTU: return {a < b, 1'b0};
            OP_BGEU: return {a >= b, 1'b0};
            default: return 2'b01;
        endcase
    endfunction

    // A new request fits if the output register is empty or is draining this cycle.
    assign w_can_accept = !i_rst && ((r_state == S_EMPTY) || i_rsp_ready);

    // Find the first valid requester at or after the pointer (scan down so the smallest offset wins).
    always_comb begin
        w_found = 1'b0;
        w_gidx  = '0;
        w_sum   = '0;
        for (int off = NREQ - 1; off >= 0; off--) begin
            w_sum = {1'b0, r_ptr} + (IDW+1)'(off);
            if (w_sum >= (IDW+1)'(NREQ))
                w_sum = w_sum - (IDW+1)'(NREQ);
            if (i_req_valid[w_sum[IDW-1:0]]) begin
                w_found = 1'b1;
                w_gidx  = w_sum[IDW-1:0];
            end
        end
    end

    assign w_xfer    = w_found && w_can_accept;
    assign w_ptr_nxt = (w_gidx == IDW'(NREQ - 1)) ? '0 : w_gidx + IDW'(1);

    // Route the winner's operands to the comparator and build the one-hot grant.
    always_comb begin
        w_a     = '0;
        w_b     = '0;
        w_op    = '0;
        w_grant = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (w_gidx == IDW'(k)) begin
                w_a        = i_req_a[32*k +: 32];
                w_b        = i_req_b[32*k +: 32];
                w_op       = i_req_cmpop[3*k +: 3];
                w_grant[k] = w_xfer;
            end
        end
    end

    assign w_res       = cmp_eval(w_a, w_b, w_op);
    assign o_req_ready = w_grant;

    // Response-stage FSM: capture on transfer, drain on consumer ready, hold while stalled.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_EMPTY;
            r_ptr     <= '0;
            r_taken   <= 1'b0;
            r_id      <= '0;
            r_illegal <= 1'b0;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_xfer) begin
                        r_state   <= S_FULL;
                        r_taken   <= w_res[1];
                        r_illegal <= w_res[0];
                        r_id      <= w_gidx;
                        r_ptr     <= w_ptr_nxt;
                    end
                end
                S_FULL: begin
                    if (w_xfer) begin
                        r_taken   <= w_res[1];
                        r_illegal <= w_res[0];
                        r_id      <= w_gidx;
                        r_ptr     <= w_ptr_nxt;
                    end else if (i_rsp_ready) begin
                        r_state   <= S_EMPTY;
                    end
                end
                default: r_state <= S_EMPTY;
            endcase
        end
    end

    assign o_rsp_valid   = (r_state == S_FULL);
    assign o_rsp_taken   = r_taken;
    assign o_rsp_id      = r_id;
    assign o_rsp_illegal = r_illegal;

endmodule
